// File: rtl/jk_ff.sv
// jk_ff: bank of WIDTH independent positive-edge JK flip-flops with an
// asynchronous active-high reset to RESET_VALUE and complementary outputs.
module jk_ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // Per-slice J/K decode: toggle, set, reset or hold. Slices never interact.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            assign q_next[gi] = (J[gi] & K[gi]) ? ~q_reg[gi] :
                                J[gi]           ? 1'b1       :
                                K[gi]           ? 1'b0       :
                                                  q_reg[gi];
        end
    endgenerate

    // State register; reset acts immediately and overrides any coincident edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q    = q_reg;
    // Complement is derived from the single state register, so it can never match Q
    assign Qbar = ~q_reg;

endmodule

// File: tb/tb_jk_ff.sv
// tb_jk_ff: table-driven, directed and randomized checks of jk_ff at
// WIDTH=1 (default), WIDTH=4 with RESET_VALUE=4'b1010 and WIDTH=8.
module tb_jk_ff;

    logic       clk;
    logic       rst1, rst4, rst8;
    logic [0:0] j1, k1, q1, qb1;
    logic [3:0] j4, k4, q4, qb4;
    logic [7:0] j8, k8, q8, qb8;

    int tests;
    int fails;

    localparam logic [7:0] RV8 = 8'hA5;

    jk_ff u_dut1 (
        .CLK (clk), .RST (rst1), .J (j1), .K (k1), .Q (q1), .Qbar (qb1)
    );

    jk_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut4 (
        .CLK (clk), .RST (rst4), .J (j4), .K (k4), .Q (q4), .Qbar (qb4)
    );

    jk_ff #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .CLK (clk), .RST (rst8), .J (j8), .K (k8), .Q (q8), .Qbar (qb8)
    );

    // Rising edges at 5, 15, 25 ns ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic rst;
        logic j;
        logic k;
        logic exp_q;
        string name;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s: %b at %0t", name, act, $time);
        end
    endtask

    // Reference behaviour of one bank, written from the J/K truth table
    function automatic logic [7:0] ref_next(input logic [7:0] q, input logic [7:0] j,
                                            input logic [7:0] k);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            if (j[b] && k[b])  r[b] = ~q[b];
            else if (j[b])     r[b] = 1'b1;
            else if (k[b])     r[b] = 1'b0;
            else               r[b] = q[b];
        end
        return r;
    endfunction

    initial begin
        vec_t       vecs [11];
        logic [7:0] model;
        logic       do_rst;

        tests = 0;
        fails = 0;
        rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
        rst4 = 1'b0; j4 = 4'b0; k4 = 4'b0;
        rst8 = 1'b0; j8 = 8'b0; k8 = 8'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, "rst_jk00"};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, "rst_jk01"};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, "rst_jk10"};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, "rst_jk11"};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, "hold_after_release"};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, "reset_k"};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, "set_j"};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, "toggle0"};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, "toggle1"};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, "toggle2"};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, "toggle3"};

        // ---- WIDTH=1 table: inputs applied at 4 ns + 10n, checked 1 ns after each edge
        #4;
        for (int i = 0; i < 11; i++) begin
            rst1 = vecs[i].rst;
            j1   = vecs[i].j;
            k1   = vecs[i].k;
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_q"},    {7'b0, q1},  {7'b0, vecs[i].exp_q});
            chk({vecs[i].name, "_qbar"}, {7'b0, qb1}, {7'b0, ~vecs[i].exp_q});
            #8;
        end

        // ---- Async reset pulse between edges (now t=114, Q=1)
        j1 = 1'b0; k1 = 1'b0;
        @(posedge clk); #1;                                   // t=116
        chk("hold_before_pulse", {7'b0, q1}, 8'd1);
        #2 rst1 = 1'b1;                                       // t=118
        #1;
        chk("async_pulse_q",    {7'b0, q1},  8'd0);
        chk("async_pulse_qbar", {7'b0, qb1}, 8'd1);
        #1 rst1 = 1'b0;                                       // t=120
        #4 j1 = 1'b1; k1 = 1'b1;                              // t=124
        @(posedge clk); #1;                                   // t=126
        chk("toggle_resume", {7'b0, q1}, 8'd1);

        // ---- Reset released 1 ns before an edge with J=1,K=0
        #2 rst1 = 1'b1;                                       // t=128
        #1;
        chk("rst_again", {7'b0, q1}, 8'd0);
        #5 j1 = 1'b1; k1 = 1'b0; rst1 = 1'b0;                 // t=134
        @(posedge clk); #1;                                   // t=136
        chk("release_then_set", {7'b0, q1}, 8'd1);

        // ---- Reset coinciding with an edge wins
        #8 j1 = 1'b1; k1 = 1'b0;                              // t=144
        @(posedge clk);
        rst1 = 1'b1;
        #1;
        chk("rst_at_edge", {7'b0, q1}, 8'd0);
        #3 rst1 = 1'b0;

        // ---- WIDTH=4, RESET_VALUE=1010
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        chk("w4_reset_q",    {4'b0, q4},  8'b0000_1010);
        chk("w4_reset_qbar", {4'b0, qb4}, 8'b0000_0101);
        j4 = 4'b0011; k4 = 4'b0101;
        @(posedge clk); #1;
        chk("w4_reset_holds_q", {4'b0, q4}, 8'b0000_1010);
        #2 rst4 = 1'b0;
        @(posedge clk); #1;
        chk("w4_mixed_q",    {4'b0, q4},  8'b0000_1011);
        chk("w4_mixed_qbar", {4'b0, qb4}, 8'b0000_0100);

        // ---- WIDTH=8 randomized against the reference model
        @(negedge clk);
        rst8 = 1'b1;
        model = RV8;
        #1;
        chk("w8_reset_q", q8, model);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            do_rst = ($urandom_range(0, 15) == 0);
            j8 = 8'($urandom);
            k8 = 8'($urandom);
            rst8 = do_rst;
            if (do_rst) begin
                model = RV8;
                #1;
                chk("w8_async_q", q8, model);
            end
            @(posedge clk); #1;
            if (!do_rst) model = ref_next(model, j8, k8);
            chk("w8_rand_q",    q8,  model);
            chk("w8_rand_qbar", qb8, ~model);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
